bomb_game_ctrl: RTL and testbench

BOMB_GAME_CTRL -- requirements
Module: bomb_game_ctrl

---
 rtl/bomb_game_ctrl_pkg.sv | 25 ++
 rtl/bomb_game_ctrl_bcd_down_sat.sv | 45 ++++
 rtl/bomb_game_ctrl.sv | 141 ++++++++++++++
 tb/tb_bomb_game_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bomb_game_ctrl_pkg.sv
// Shared definitions for the bomb game stages: state encoding, BCD width,
// wire count and a binary-to-BCD helper.
package bomb_game_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARMED    = 2'd1,
        S_DEFUSED  = 2'd2,
        S_EXPLODED = 2'd3
    } game_state_t;

    localparam int BCD_W     = 4;
    localparam int NUM_WIRES = 4;
    localparam int DEC_W     = 8;

    // Values are at most 99, so two BCD digits always suffice.
    function automatic logic [2*BCD_W-1:0] bin_to_bcd(input logic [6:0] value);
        logic [6:0] tens_v;
        logic [6:0] ones_v;
        tens_v = value / 7'd10;
        ones_v = value % 7'd10;
        return {tens_v[BCD_W-1:0], ones_v[BCD_W-1:0]};
    endfunction

endpackage

// File: rtl/bomb_game_ctrl_bcd_down_sat.sv
// Two-digit BCD down counter: load to INIT, subtract an arbitrary amount
// with saturation at 00, and report zero now / zero after this decrement.
module bcd_down_sat
    import bomb_game_ctrl_pkg::*;
#(
    parameter int INIT = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec_en,
    input  logic [DEC_W-1:0] dec_amt,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             zero,
    output logic             dec_zero
);

    localparam logic [2*BCD_W-1:0] INIT_BCD = bin_to_bcd(7'(INIT));

    logic [6:0]       cur;
    logic [DEC_W-1:0] cur_ext;
    logic [DEC_W-1:0] diff;
    logic [6:0]       next_bin;

    // Subtract in binary; the digit pair is converted back on store.
    always_comb begin
        cur      = 7'(tens) * 7'd10 + 7'(ones);
        cur_ext  = {1'b0, cur};
        diff     = (dec_amt >= cur_ext) ? '0 : (cur_ext - dec_amt);
        next_bin = diff[6:0];
        dec_zero = dec_en && (diff == '0);
    end

    assign zero = (tens == '0) && (ones == '0);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            {tens, ones} <= INIT_BCD;
        end else if (dec_en) begin
            {tens, ones} <= bin_to_bcd(next_bin);
        end
    end

endmodule

// File: rtl/bomb_game_ctrl.sv
// Bomb game controller: arms on start with all wires intact, counts down
// in BCD, and resolves wire cuts into defuse, penalty or detonation.
module bomb_game_ctrl
    import bomb_game_ctrl_pkg::*;
#(
    parameter int TICK_DIV    = 1000,
    parameter int START_SEC   = 60,
    parameter int PENALTY_SEC = 10,
    parameter int SAFE_WIRE   = 0,
    parameter int TRAP_WIRE   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_WIRES-1:0] wire_in,
    input  logic                 repeat_rst,
    output logic                 armed,
    output logic                 fail,
    output logic                 success,
    output logic [BCD_W-1:0]     sec_tens,
    output logic [BCD_W-1:0]     sec_ones,
    output logic                 tick,
    output game_state_t          dbg_state
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    game_state_t          state_q;
    logic [PRESC_W-1:0]   presc_q;
    logic [NUM_WIRES-1:0] wire_q;
    logic [NUM_WIRES-1:0] cut;
    logic [2:0]           pen_cnt;
    logic                 trap_cut;
    logic                 safe_cut;
    logic                 tick_now;
    logic                 start_ok;
    logic                 load;
    logic                 dec_en;
    logic [DEC_W-1:0]     dec_amt;
    logic                 zero;
    logic                 dec_zero;

    assign dbg_state = state_q;

    always_comb begin
        cut      = wire_q & ~wire_in;
        trap_cut = cut[TRAP_WIRE];
        safe_cut = cut[SAFE_WIRE];
        pen_cnt  = '0;
        for (int i = 0; i < NUM_WIRES; i++) begin
            if (i != SAFE_WIRE && i != TRAP_WIRE && cut[i]) begin
                pen_cnt = pen_cnt + 3'd1;
            end
        end
        tick_now = (state_q == S_ARMED) && !zero &&
                   (presc_q == PRESC_W'(TICK_DIV - 1));
        start_ok = (state_q == S_IDLE) && start && (wire_in == '1);
        load     = repeat_rst || start_ok;
        dec_en   = 1'b0;
        dec_amt  = '0;
        // Trap freezes the display; safe keeps only the tick; otherwise
        // penalties and the tick are applied together.
        if (state_q == S_ARMED && !zero && !repeat_rst && !trap_cut) begin
            if (safe_cut) begin
                dec_en  = tick_now;
                dec_amt = DEC_W'(1);
            end else begin
                dec_en  = tick_now || (pen_cnt != '0);
                dec_amt = DEC_W'(int'(pen_cnt) * PENALTY_SEC) + DEC_W'(tick_now);
            end
        end
    end

    bcd_down_sat #(
        .INIT(START_SEC)
    ) u_bcd (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .dec_en  (dec_en),
        .dec_amt (dec_amt),
        .tens    (sec_tens),
        .ones    (sec_ones),
        .zero    (zero),
        .dec_zero(dec_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            armed   <= 1'b0;
            fail    <= 1'b0;
            success <= 1'b0;
            tick    <= 1'b0;
            presc_q <= '0;
            wire_q  <= '1;
        end else begin
            wire_q <= wire_in;
            tick   <= 1'b0;
            if (repeat_rst) begin
                state_q <= S_IDLE;
                armed   <= 1'b0;
                fail    <= 1'b0;
                success <= 1'b0;
                presc_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_ok) begin
                            state_q <= S_ARMED;
                            armed   <= 1'b1;
                            presc_q <= '0;
                        end
                    end
                    S_ARMED: begin
                        if (zero || trap_cut) begin
                            state_q <= S_EXPLODED;
                            armed   <= 1'b0;
                            fail    <= 1'b1;
                        end else if (safe_cut) begin
                            armed <= 1'b0;
                            if (tick_now && dec_zero) begin
                                state_q <= S_EXPLODED;
                                fail    <= 1'b1;
                            end else begin
                                state_q <= S_DEFUSED;
                                success <= 1'b1;
                            end
                        end else begin
                            presc_q <= tick_now ? '0 : (presc_q + PRESC_W'(1));
                            tick    <= tick_now;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// Directed bench for bomb_game_ctrl: a vector table for the main flow plus
// hand-written sequences for countdown, penalties, priorities and resets.
module tb_bomb_game_ctrl;
    import bomb_game_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    // main instance: 60 s start, 4-cycle seconds
    logic       start, repeat_rst;
    logic [3:0] wire_in;
    logic       armed, fail, success, tick;
    logic [3:0] sec_tens, sec_ones;
    game_state_t dbg_state;
    // short instance: 3 s start, 4-cycle seconds
    logic       start_s, repeat_s;
    logic [3:0] wire_s;
    logic       armed_s, fail_s, success_s, tick_s;
    logic [3:0] tens_s, ones_s;
    game_state_t state_s;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       start;
        logic [3:0] w;
        logic       rr;
        logic       armed, fail, success, tick;
        logic [3:0] tens, ones;
    } vec_t;

    always #5 clk = ~clk;

    bomb_game_ctrl #(.TICK_DIV(4), .START_SEC(60), .PENALTY_SEC(10),
                     .SAFE_WIRE(0), .TRAP_WIRE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .wire_in(wire_in),
        .repeat_rst(repeat_rst), .armed(armed), .fail(fail),
        .success(success), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .tick(tick), .dbg_state(dbg_state));

    bomb_game_ctrl #(.TICK_DIV(4), .START_SEC(3), .PENALTY_SEC(10),
                     .SAFE_WIRE(0), .TRAP_WIRE(1)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .wire_in(wire_s),
        .repeat_rst(repeat_s), .armed(armed_s), .fail(fail_s),
        .success(success_s), .sec_tens(tens_s), .sec_ones(ones_s),
        .tick(tick_s), .dbg_state(state_s));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_main(input string tag, input logic a, input logic f,
                              input logic s, input logic t,
                              input logic [3:0] te, input logic [3:0] on);
        check({tag, " armed"}, armed, a);
        check({tag, " fail"}, fail, f);
        check({tag, " success"}, success, s);
        check({tag, " tick"}, tick, t);
        check({tag, " tens"}, sec_tens, te);
        check({tag, " ones"}, sec_ones, on);
    endtask

    task automatic check_short(input string tag, input logic a, input logic f,
                               input logic s, input logic t,
                               input logic [3:0] te, input logic [3:0] on);
        check({tag, " armed"}, armed_s, a);
        check({tag, " fail"}, fail_s, f);
        check({tag, " success"}, success_s, s);
        check({tag, " tick"}, tick_s, t);
        check({tag, " tens"}, tens_s, te);
        check({tag, " ones"}, ones_s, on);
    endtask

    task automatic wait_display(input string tag, input logic [3:0] te,
                                input logic [3:0] on, input int budget);
        int n;
        n = 0;
        while (!(sec_tens == te && sec_ones == on) && n < budget) begin
            step();
            n++;
        end
        check({tag, " reached display"}, {sec_tens, sec_ones}, {te, on});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[16];
        vecs[0]  = '{1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 4'd0};
        vecs[1]  = '{1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 4'd0};
        vecs[2]  = '{1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 4'd0};
        vecs[3]  = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 4'd0};
        vecs[4]  = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 4'd0};
        vecs[5]  = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 4'd0};
        vecs[6]  = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 4'd9};
        vecs[7]  = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd9};
        vecs[8]  = '{1'b0, 4'hB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd9};
        vecs[9]  = '{1'b0, 4'hB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd9};
        vecs[10] = '{1'b0, 4'hB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 4'd8};
        vecs[11] = '{1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 4'd8};
        vecs[12] = '{1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 4'd8};
        vecs[13] = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 4'd8};
        vecs[14] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 4'd0};
        vecs[15] = '{1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 4'd0};

        rst = 1'b1;
        start = 1'b0; repeat_rst = 1'b0; wire_in = 4'hF;
        start_s = 1'b0; repeat_s = 1'b0; wire_s = 4'hF;
        step();
        step();
        check_main("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 4'd0);
        check("reset state", int'(dbg_state), int'(S_IDLE));
        check_short("reset short", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3);
        rst = 1'b0;

        // Table: arm, tick, penalty, defuse, hold, restart.
        for (int i = 0; i < 16; i++) begin
            start = vecs[i].start;
            wire_in = vecs[i].w;
            repeat_rst = vecs[i].rr;
            step();
            check_main($sformatf("vec%0d", i), vecs[i].armed, vecs[i].fail,
                       vecs[i].success, vecs[i].tick, vecs[i].tens, vecs[i].ones);
        end
        start = 1'b0; repeat_rst = 1'b0; wire_in = 4'hF;

        // Defuse at 60: display frozen, ticks stop.
        start = 1'b1; step(); start = 1'b0;
        check_main("arm60", 1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 4'd0);
        wire_in = 4'hE; step();
        check_main("defuse60", 1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 4'd0);
        check("defuse60 state", int'(dbg_state), int'(S_DEFUSED));
        for (int k = 0; k < 8; k++) begin
            step();
            check_main($sformatf("defused hold%0d", k), 1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 4'd0);
        end
        repeat_rst = 1'b1; step(); repeat_rst = 1'b0;
        wire_in = 4'hF; step();

        // Penalty to 50, then penalty at 05 saturates to 00 and explodes.
        start = 1'b1; step(); start = 1'b0;
        wire_in = 4'hB; step();
        check_main("penalty50", 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0);
        wait_display("to05", 4'd0, 4'd5, 300);
        wire_in = 4'h3; step();
        check_main("sat00", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        check_main("sat boom", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        check("sat boom state", int'(dbg_state), int'(S_EXPLODED));

        // Restart from EXPLODED; start with a cut wire is ignored.
        repeat_rst = 1'b1; step(); repeat_rst = 1'b0;
        check_main("restart", 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 4'd0);
        check("restart state", int'(dbg_state), int'(S_IDLE));
        wire_in = 4'hB; start = 1'b1; step();
        check("cut start armed", armed, 1'b0);
        step();
        check("cut start state", int'(dbg_state), int'(S_IDLE));
        start = 1'b0; wire_in = 4'hF; step();

        // Trap and safe cut together: trap wins.
        start = 1'b1; step(); start = 1'b0;
        wire_in = 4'hC; step();
        check_main("trap+safe", 1'b0, 1'b1, 1'b0, 1'b0, 4'd6, 4'd0);
        step();
        check_main("trap+safe hold", 1'b0, 1'b1, 1'b0, 1'b0, 4'd6, 4'd0);
        repeat_rst = 1'b1; wire_in = 4'hF; step(); repeat_rst = 1'b0; step();

        // Synchronous reset mid-countdown at 42.
        start = 1'b1; step(); start = 1'b0;
        wait_display("to42", 4'd4, 4'd2, 300);
        rst = 1'b1; step(); rst = 1'b0;
        check_main("rst@42", 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 4'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            check_main($sformatf("post rst%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 4'd0);
        end

        // Short instance: full countdown 03 -> 00, fail one cycle after 00.
        start_s = 1'b1; step(); start_s = 1'b0;
        check_short("s arm", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3);
        for (int k = 1; k <= 13; k++) begin
            logic       et;
            logic [3:0] eo;
            step();
            et = (k % 4 == 0) && (k <= 12);
            eo = (k <= 12) ? 4'(3 - k / 4) : 4'd0;
            check_short($sformatf("s cnt%0d", k), (k < 13), (k == 13), 1'b0, et, 4'd0, eo);
        end
        start_s = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_short($sformatf("s hold%0d", k), 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        end
        start_s = 1'b0;

        // Safe cut on a tick cycle: defused with the decrement applied.
        repeat_s = 1'b1; step(); repeat_s = 1'b0;
        start_s = 1'b1; step(); start_s = 1'b0;
        repeat (3) step();
        wire_s = 4'hE; step();
        check_short("s safe+tick", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd2);

        // Safe cut on the tick that reaches 00: explosion wins.
        repeat_s = 1'b1; step(); repeat_s = 1'b0;
        wire_s = 4'hF; step();
        start_s = 1'b1; step(); start_s = 1'b0;
        repeat (11) step();
        check_short("s before last", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1);
        wire_s = 4'hE; step();
        check_short("s safe+tick00", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
